// File: rtl/gemm_fifo_writer_if.sv
// rtl/gemm_fifo_writer_if.sv - request, scratchpad read and GEMM FIFO write signals of the FIFO writer
interface gemm_fifo_writer_if #(
  parameter int ROW_W   = 64,
  parameter int ROW_S_W = 2,
  parameter int ADDR_W  = 10
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_new_weight;
  logic [ADDR_W-1:0]        req_weight_base;
  logic [ADDR_W-1:0]        req_input_base;
  logic [ADDR_W-1:0]        req_partial_base;

  logic                     sram_ren;
  logic [ADDR_W-1:0]        sram_raddr;
  logic                     sram_rvalid;
  logic [ROW_W-1:0]         sram_rdata;

  logic                     gemmFIFO0_WEN;
  logic                     gemmFIFO1_WEN;
  logic                     gemmFIFO2_WEN;
  logic                     gemmFIFO3_WEN;
  logic [ROW_S_W+ROW_W-1:0] gemmFIFO0_wdata;
  logic [ROW_S_W+ROW_W-1:0] gemmFIFO1_wdata;
  logic [ROW_S_W+ROW_W-1:0] gemmFIFO2_wdata;
  logic [ROW_S_W+ROW_W-1:0] gemmFIFO3_wdata;
  logic                     gemmFIFO0_full;
  logic                     gemmFIFO1_full;
  logic                     gemmFIFO2_full;
  logic                     gemmFIFO3_full;

  logic                     busy;

  modport master (
    input  req_valid, req_new_weight, req_weight_base, req_input_base, req_partial_base,
    input  sram_rvalid, sram_rdata,
    input  gemmFIFO0_full, gemmFIFO1_full, gemmFIFO2_full, gemmFIFO3_full,
    output req_ready, sram_ren, sram_raddr,
    output gemmFIFO0_WEN, gemmFIFO1_WEN, gemmFIFO2_WEN, gemmFIFO3_WEN,
    output gemmFIFO0_wdata, gemmFIFO1_wdata, gemmFIFO2_wdata, gemmFIFO3_wdata,
    output busy
  );

  modport slave (
    output req_valid, req_new_weight, req_weight_base, req_input_base, req_partial_base,
    output sram_rvalid, sram_rdata,
    output gemmFIFO0_full, gemmFIFO1_full, gemmFIFO2_full, gemmFIFO3_full,
    input  req_ready, sram_ren, sram_raddr,
    input  gemmFIFO0_WEN, gemmFIFO1_WEN, gemmFIFO2_WEN, gemmFIFO3_WEN,
    input  gemmFIFO0_wdata, gemmFIFO1_wdata, gemmFIFO2_wdata, gemmFIFO3_wdata,
    input  busy
  );
endinterface

// File: rtl/gemm_fifo_writer.sv
// rtl/gemm_fifo_writer.sv - fetches weight/input/partial rows from scratchpad into the GEMM FIFOs, then a descriptor
module gemm_fifo_writer #(
  parameter int ROWS    = 4,
  parameter int ROW_W   = 64,
  parameter int ROW_S_W = 2,
  parameter int ADDR_W  = 10
) (
  input  logic                CLK,
  input  logic                nRST,
  gemm_fifo_writer_if.master  bus
);
  localparam int WD_W = ROW_S_W + ROW_W;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, DESC} state_t;
  typedef enum logic [1:0] {PH_WEIGHT, PH_INPUT, PH_PARTIAL} phase_t;

  state_t             r_state, w_state;
  phase_t             r_phase, w_phase;
  logic [ROW_S_W-1:0] r_row, w_row;
  logic [ROW_W-1:0]   r_buf, w_buf;
  logic [ADDR_W-1:0]  r_wbase, w_wbase;
  logic [ADDR_W-1:0]  r_ibase, w_ibase;
  logic [ADDR_W-1:0]  r_pbase, w_pbase;
  logic               r_new_weight, w_new_weight;

  logic [ADDR_W-1:0]  w_base;
  logic [WD_W-1:0]    w_row_word;
  logic               w_full;
  logic               w_last_row;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_phase      <= PH_WEIGHT;
      r_row        <= '0;
      r_buf        <= '0;
      r_wbase      <= '0;
      r_ibase      <= '0;
      r_pbase      <= '0;
      r_new_weight <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_phase      <= w_phase;
      r_row        <= w_row;
      r_buf        <= w_buf;
      r_wbase      <= w_wbase;
      r_ibase      <= w_ibase;
      r_pbase      <= w_pbase;
      r_new_weight <= w_new_weight;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_phase      = r_phase;
    w_row        = r_row;
    w_buf        = r_buf;
    w_wbase      = r_wbase;
    w_ibase      = r_ibase;
    w_pbase      = r_pbase;
    w_new_weight = r_new_weight;

    bus.req_ready       = (r_state == IDLE);
    bus.busy            = (r_state != IDLE);
    bus.sram_ren        = 1'b0;
    bus.sram_raddr      = '0;
    bus.gemmFIFO0_WEN   = 1'b0;
    bus.gemmFIFO1_WEN   = 1'b0;
    bus.gemmFIFO2_WEN   = 1'b0;
    bus.gemmFIFO3_WEN   = 1'b0;
    bus.gemmFIFO0_wdata = '0;
    bus.gemmFIFO1_wdata = '0;
    bus.gemmFIFO2_wdata = '0;
    bus.gemmFIFO3_wdata = '0;

    case (r_phase)
      PH_WEIGHT: begin w_base = r_wbase; w_full = bus.gemmFIFO0_full; end
      PH_INPUT:  begin w_base = r_ibase; w_full = bus.gemmFIFO1_full; end
      default:   begin w_base = r_pbase; w_full = bus.gemmFIFO2_full; end
    endcase
    w_row_word = {r_row, r_buf};
    w_last_row = (r_row == ROW_S_W'(ROWS - 1));

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_wbase      = bus.req_weight_base;
          w_ibase      = bus.req_input_base;
          w_pbase      = bus.req_partial_base;
          w_new_weight = bus.req_new_weight;
          w_row        = '0;
          w_phase      = bus.req_new_weight ? PH_WEIGHT : PH_INPUT;
          w_state      = ISSUE;
        end
      end
      ISSUE: begin
        bus.sram_ren   = 1'b1;
        bus.sram_raddr = w_base + ADDR_W'(r_row);
        w_state        = WAIT;
      end
      WAIT: begin
        if (bus.sram_rvalid) begin
          w_buf   = bus.sram_rdata;
          w_state = PUSH;
        end
      end
      PUSH: begin
        // wdata is presented during stalls too, so the FIFO sees it stable until the write lands
        case (r_phase)
          PH_WEIGHT: begin bus.gemmFIFO0_wdata = w_row_word; bus.gemmFIFO0_WEN = !w_full; end
          PH_INPUT:  begin bus.gemmFIFO1_wdata = w_row_word; bus.gemmFIFO1_WEN = !w_full; end
          default:   begin bus.gemmFIFO2_wdata = w_row_word; bus.gemmFIFO2_WEN = !w_full; end
        endcase
        if (!w_full) begin
          if (!w_last_row) begin
            w_row   = r_row + ROW_S_W'(1);
            w_state = ISSUE;
          end else begin
            w_row = '0;
            case (r_phase)
              PH_WEIGHT: begin w_phase = PH_INPUT;   w_state = ISSUE; end
              PH_INPUT:  begin w_phase = PH_PARTIAL; w_state = ISSUE; end
              default:   w_state = DESC;
            endcase
          end
        end
      end
      DESC: begin
        bus.gemmFIFO3_wdata = {{(WD_W-1){1'b0}}, r_new_weight};
        if (!bus.gemmFIFO3_full) begin
          bus.gemmFIFO3_WEN = 1'b1;
          w_state           = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
endmodule

// File: doc/gemm_fifo_writer.md
Name: gemm_fifo_writer

Overview:
- Producer side of the four GEMM FIFOs drained by the systolic-array GEMM FSM.
- Accepts one GEMM request at a time, carrying base scratchpad row addresses for the weight, input and partial-sum matrices plus a new_weight flag.
- Fetches rows from the scratchpad SRAM read port and pushes them into FIFO0 (weights), FIFO1 (inputs) and FIFO2 (partial sums).
- Finishes each request with one descriptor entry into FIFO3; full-flag backpressure is honoured on every FIFO.

Parameters:
- ROWS, 4, rows per matrix (systolic array dimension).
- ROW_W, 64, bits per row (matches BITS_PER_ROW).
- ROW_S_W, 2, row-select width, equal to clog2(ROWS).
- ADDR_W, 10, scratchpad row address width.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- req_valid  in  1  GEMM request valid
- req_ready  out  1  writer idle, request accepted when req_valid&&req_ready
- req_new_weight  in  1  reload weights for this GEMM
- req_weight_base  in  ADDR_W  first weight row address
- req_input_base  in  ADDR_W  first input row address
- req_partial_base  in  ADDR_W  first partial-sum row address
- sram_ren  out  1  scratchpad read request, one-cycle pulse
- sram_raddr  out  ADDR_W  scratchpad read address
- sram_rvalid  in  1  read data valid, any latency ≥1 cycle
- sram_rdata  in  ROW_W  read data
- gemmFIFO0_WEN..gemmFIFO3_WEN  out  1 each  FIFO write enables
- gemmFIFO0_wdata..gemmFIFO3_wdata  out  ROW_S_W+ROW_W each  {row_sel, data}
- gemmFIFO0_full..gemmFIFO3_full  in  1 each  FIFO full flags
- busy  out  1  request in progress

Behaviour:
- Reset (nRST low at a CLK edge):
  - State goes to IDLE; internal registers clear.
  - sram_ren=0, all WEN=0, all wdata=0, busy=0, req_ready=1 from the following cycle.
  - Reset mid-request abandons the request. No further WEN is issued. Late sram_rvalid pulses are ignored.
- States: IDLE, ISSUE, WAIT, PUSH, DESC.
- IDLE:
  - req_ready=1, busy=0.
  - On accept, latch the three bases and new_weight; row counter r=0.
  - Phase is WEIGHT if new_weight=1, else INPUT. Go to ISSUE.
- ISSUE (one cycle):
  - sram_ren=1, sram_raddr=base(phase)+r, modulo 2^ADDR_W (wrap-around allowed). Go to WAIT.
- WAIT:
  - Hold until sram_rvalid; capture sram_rdata into the row buffer. Go to PUSH.
  - sram_rvalid arriving outside WAIT is ignored.
- PUSH:
  - The target FIFO is 0/1/2 for WEIGHT/INPUT/PARTIAL. wdata={r[ROW_S_W-1:0], row buffer}.
  - If target full=1: WEN=0 and hold wdata stable, with no time limit.
  - If target full=0: WEN=1 for exactly one cycle.
  - After the write: if r<ROWS-1, set r++ and go to ISSUE. Otherwise set r=0, advance the phase, and go to ISSUE. The phase after PARTIAL is DESC.
- DESC:
  - gemmFIFO3_wdata: row field=0, data bit0=latched new_weight, all other data bits 0.
  - Write when gemmFIFO3_full=0, then go to IDLE. Stall otherwise.
- Rules:
  - At most one outstanding SRAM read.
  - Only one WEN is high in any cycle.
  - No FIFO write occurs while its full=1.
  - busy=1 in all states other than IDLE; req_ready=!busy.
- Order per request:
  - [ROWS weight rows, if new_weight], then ROWS input rows, then ROWS partial rows, then 1 descriptor.
  - Rows within each matrix go in ascending order.
- Latency: with SRAM latency L and no full, each row takes L+2 cycles from ISSUE to the WEN cycle. The descriptor takes 1 cycle.
- A req_valid asserted while busy is not accepted; the requester must hold it.

Test Plan:
- Reset, then a request with new_weight=1, bases 0x010/0x020/0x030, SRAM latency 1, no full -> raddr sequence 0x010–0x013, 0x020–0x023, 0x030–0x033. FIFO0/1/2 each receive row_sel 0,1,2,3 with the matching data. FIFO3 receives data=1. busy falls the cycle after the FIFO3 write.
- new_weight=0, same bases -> no FIFO0 write and no 0x01x reads. Exactly 8 row writes, then FIFO3 data=0.
- gemmFIFO1_full held high for 5 cycles during the row-2 push -> WEN1 stays 0 and wdata stays stable for all 5 cycles. One WEN1 pulse follows the deassert. No SRAM read is issued during the stall.
- req_weight_base=0x3FE, ADDR_W=10 -> raddr 0x3FE, 0x3FF, 0x000, 0x001.
- Second req_valid held during a busy request -> it is not accepted until IDLE; req_ready rises the cycle after the FIFO3 write, and the new bases are then latched.
- nRST low during the WAIT of input row 1, with sram_rvalid arriving next cycle -> no WEN follows, outputs are at reset values, and req_ready=1 after reset is released.
